// File: rtl/systolic_pkg.sv
// Shared defaults, FSM states and registered control bundle
// for the systolic tile sequencer.
package systolic_pkg;

    localparam int N_DEF   = 8;
    localparam int DW_DEF  = 16;
    localparam int SW_DEF  = 36;
    localparam int TMO_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WAIT,
        S_OUT
    } state_e;

    typedef struct packed {
        logic busy;
        logic op_ready;
        logic arr_en;
        logic arr_done;
        logic res_valid;
    } ctl_t;

    function automatic ctl_t ctl_of(state_e s);
        ctl_t c;
        c.busy      = (s != S_IDLE);
        c.op_ready  = (s == S_FEED);
        c.arr_en    = (s == S_FEED) || (s == S_DRAIN) || (s == S_WAIT);
        c.arr_done  = (s == S_DRAIN);
        c.res_valid = (s == S_OUT);
        return c;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Zero-reset shift register delaying one operand lane
// by DEPTH cycles (DEPTH >= 1).
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_tile_seq.sv
// Tile sequencer: clears the array, streams skewed operands,
// drains, waits for completion and returns result rows.
module systolic_tile_seq
    import systolic_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int DW  = DW_DEF,
    parameter int SW  = SW_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          k_len,
    output logic                busy,
    output logic                err,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [N*DW-1:0]     op_act,
    input  logic [N*DW-1:0]     op_wgt,
    output logic                arr_en,
    output logic [N*DW-1:0]     arr_act,
    output logic [N*DW-1:0]     arr_wgt,
    output logic [N-1:0]        arr_done,
    input  logic [N*N-1:0]      arr_out_dones,
    input  logic [N*N*SW-1:0]   arr_results,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N*SW-1:0]     res_row,
    output logic [2:0]          res_idx
);

    localparam int CW = $clog2(TMO + 2 * N) + 1;
    localparam int RW = N * SW;

    state_e              state_q, state_d;
    ctl_t                ctl_q;
    logic [7:0]          k_q;
    logic [7:0]          beat_q, beat_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic                err_q;
    logic [N*N*SW-1:0]   buf_q;
    logic                snap, tmo_hit;
    logic                beat_ok;
    logic [N*DW-1:0]     act_in, wgt_in;

    // Stalls and non-feed states push zeros so the array never stops.
    assign beat_ok = ctl_q.op_ready && op_valid;
    assign act_in  = beat_ok ? op_act : '0;
    assign wgt_in  = beat_ok ? op_wgt : '0;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap    = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                beat_d  = '0;
                cnt_d   = '0;
                state_d = (k_q == 8'd0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                if (beat_ok) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q + 8'd1 == k_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(2 * N - 2)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (&arr_out_dones) begin
                    snap    = 1'b1;
                    idx_d   = '0;
                    state_d = S_OUT;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    snap    = 1'b1;
                    tmo_hit = 1'b1;
                    idx_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (ctl_q.res_valid && res_ready) begin
                    if (idx_q == 3'(N - 1)) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            k_q     <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_of(state_d);
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (state_q == S_IDLE && start) begin
                k_q   <= k_len;
                err_q <= 1'b0;
            end
            if (tmo_hit) err_q <= 1'b1;
            if (snap) buf_q <= arr_results;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_l0
            assign arr_act[DW-1:0] = act_in[DW-1:0];
            assign arr_wgt[DW-1:0] = wgt_in[DW-1:0];
        end else begin : g_sk
            skew_line #(.DEPTH(i), .W(DW)) u_act (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (act_in[i*DW +: DW]),
                .q_o   (arr_act[i*DW +: DW])
            );
            skew_line #(.DEPTH(i), .W(DW)) u_wgt (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (wgt_in[i*DW +: DW]),
                .q_o   (arr_wgt[i*DW +: DW])
            );
        end
    end

    assign busy      = ctl_q.busy;
    assign op_ready  = ctl_q.op_ready;
    assign arr_en    = ctl_q.arr_en;
    assign arr_done  = {N{ctl_q.arr_done}};
    assign res_valid = ctl_q.res_valid;
    assign err       = err_q;
    assign res_idx   = idx_q;
    assign res_row   = buf_q[int'(idx_q) * RW +: RW];

endmodule

// File: tb/tb_systolic_tile_seq.sv
// Bench for systolic_tile_seq: behavioural output-stationary
// array model, table of tiles, scoreboard of expected rows.
module tb_systolic_tile_seq;

    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int SW   = 36;
    localparam int TMO  = 64;
    localparam int KMAX = 16;
    localparam int RW   = N * SW;
    localparam int LIM  = 2000;

    localparam int P_ONES  = 0;
    localparam int P_IDENT = 1;
    localparam int P_RAND  = 2;
    localparam int P_KEEP  = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        k_len;
    logic              busy;
    logic              err;
    logic              op_valid;
    logic              op_ready;
    logic [N*DW-1:0]   op_act;
    logic [N*DW-1:0]   op_wgt;
    logic              arr_en;
    logic [N*DW-1:0]   arr_act;
    logic [N*DW-1:0]   arr_wgt;
    logic [N-1:0]      arr_done;
    logic [N*N-1:0]    arr_out_dones;
    logic [N*N*SW-1:0] arr_results;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_row;
    logic [2:0]        res_idx;

    logic stuck;
    int   checks = 0;
    int   errors = 0;
    int   cur_t  = -1;

    typedef struct {
        int   k;
        int   pat;
        int   stall_at;
        int   stall_len;
        int   hold_row;
        logic stuck;
        logic restart;
        logic exp_err;
        int   exp_wait;
    } vec_t;

    typedef struct {
        logic [2:0]    idx;
        logic [RW-1:0] row;
    } exp_t;

    exp_t          exp_q[$];
    vec_t          tbl[9];
    logic [DW-1:0] am [KMAX][N];
    logic [DW-1:0] bm [KMAX][N];

    systolic_tile_seq #(.N(N), .DW(DW), .SW(SW), .TMO(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .k_len         (k_len),
        .busy          (busy),
        .err           (err),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_act        (op_act),
        .op_wgt        (op_wgt),
        .arr_en        (arr_en),
        .arr_act       (arr_act),
        .arr_wgt       (arr_wgt),
        .arr_done      (arr_done),
        .arr_out_dones (arr_out_dones),
        .arr_results   (arr_results),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_row       (res_row),
        .res_idx       (res_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: activations flow right, weights flow down.
    logic [DW-1:0] ain [N][N];
    logic [DW-1:0] bin [N][N];
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic [SW-1:0] acc [N][N];
    logic          dn  [N][N];

    always_comb begin
        arr_results   = '0;
        arr_out_dones = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c == 0) ain[r][c] = arr_act[r*DW +: DW];
                else        ain[r][c] = pa[r][c-1];
                if (r == 0) bin[r][c] = arr_wgt[c*DW +: DW];
                else        bin[r][c] = pb[r-1][c];
                arr_results[(r*N+c)*SW +: SW] = acc[r][c];
                arr_out_dones[r*N+c] = dn[r][c] & ~stuck;
            end
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!arr_en) begin
                    pa[r][c]  <= '0;
                    pb[r][c]  <= '0;
                    acc[r][c] <= '0;
                    dn[r][c]  <= 1'b0;
                end else begin
                    pa[r][c]  <= ain[r][c];
                    pb[r][c]  <= bin[r][c];
                    acc[r][c] <= acc[r][c] + SW'(ain[r][c]) * SW'(bin[r][c]);
                    if (c == 0) dn[r][c] <= dn[r][c] | arr_done[r];
                    else        dn[r][c] <= dn[r][c] | dn[r][c-1];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [RW-1:0] got,
                       input logic [RW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL t%0d %s: got %0h want %0h", cur_t, nm, got, want);
        end
    endtask

    task automatic build(input vec_t v);
        exp_t          e;
        logic [SW-1:0] s;
        if (v.pat != P_KEEP) begin
            for (int k = 0; k < KMAX; k++) begin
                for (int i = 0; i < N; i++) begin
                    case (v.pat)
                        P_ONES: begin
                            am[k][i] = DW'(1);
                            bm[k][i] = DW'(1);
                        end
                        P_IDENT: begin
                            am[k][i] = (i == k) ? DW'(1) : DW'(0);
                            bm[k][i] = DW'(i + 1);
                        end
                        default: begin
                            am[k][i] = DW'($urandom_range(0, 65535));
                            bm[k][i] = DW'($urandom_range(0, 65535));
                        end
                    endcase
                end
            end
        end
        for (int r = 0; r < N; r++) begin
            e.idx = 3'(r);
            e.row = '0;
            for (int c = 0; c < N; c++) begin
                s = '0;
                for (int k = 0; k < v.k; k++)
                    s = s + SW'(am[k][r]) * SW'(bm[k][c]);
                e.row[c*SW +: SW] = s;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run_tile(input int ti, input vec_t v);
        int            beats      = 0;
        int            stall_left = v.stall_len;
        int            hold_left  = 10;
        int            cyc        = 0;
        int            rdy_cnt    = 0;
        int            wait_cnt   = 0;
        int            rows       = 0;
        logic          held       = 1'b0;
        logic          kicked     = 1'b0;
        logic [2:0]    h_idx      = '0;
        logic [RW-1:0] h_row      = '0;
        exp_t          e;
        cur_t = ti;
        build(v);
        stuck = v.stuck;
        @(negedge clk);
        start = 1'b1;
        k_len = 8'(v.k);
        @(negedge clk);
        start = 1'b0;
        k_len = 8'hff;
        while (busy && cyc < LIM) begin
            start = 1'b0;
            if (v.restart && !kicked && res_valid) begin
                start  = 1'b1;
                k_len  = 8'd0;
                kicked = 1'b1;
            end
            if (beats < v.k && op_ready && beats == v.stall_at && stall_left > 0) begin
                op_valid = 1'b0;
                stall_left--;
            end else if (beats < v.k) begin
                op_valid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    op_act[i*DW +: DW] = am[beats][i];
                    op_wgt[i*DW +: DW] = bm[beats][i];
                end
            end else begin
                op_valid = 1'b0;
                op_act   = '0;
                op_wgt   = '0;
            end
            if (op_ready) rdy_cnt++;
            if (busy && arr_en && !arr_done[0] && !op_ready) wait_cnt++;
            res_ready = !(res_valid && rows == v.hold_row && hold_left > 0);
            if (res_valid && !res_ready) hold_left--;
            if (held) begin
                chk("hold idx", RW'(res_idx), RW'(h_idx));
                chk("hold row", res_row, h_row);
            end
            held  = res_valid && !res_ready;
            h_idx = res_idx;
            h_row = res_row;
            if (res_valid && res_ready) begin
                if (rows == 0) chk("err at first row", RW'(err), RW'(v.exp_err));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL t%0d extra row: got idx %0d want none", ti, res_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("row%0d idx", rows), RW'(res_idx), RW'(e.idx));
                    chk($sformatf("row%0d data", rows), res_row, e.row);
                end
                rows++;
            end
            if (op_valid && op_ready) beats++;
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b1;
        chk("finished in budget", RW'(cyc < LIM), RW'(1));
        chk("rows delivered", RW'(rows), RW'(N));
        chk("beats consumed", RW'(beats), RW'(v.k));
        chk("op_ready cycles", RW'(rdy_cnt), RW'(v.k + v.stall_len));
        chk("wait cycles", RW'(wait_cnt), RW'(v.exp_wait));
        chk("err after tile", RW'(err), RW'(v.exp_err));
        chk("idle after tile", RW'(busy), RW'(0));
        exp_q.delete();
        stuck = 1'b0;
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        op_valid  = 1'b0;
        op_act    = '0;
        op_wgt    = '0;
        res_ready = 1'b1;
        stuck     = 1'b0;

        //          k  pat      st  sl hr  stk   rs    err   wait
        tbl[0] = '{4, P_ONES,  -1, 0, -1, 1'b0, 1'b0, 1'b0, 1};
        tbl[1] = '{8, P_IDENT, -1, 0, -1, 1'b0, 1'b0, 1'b0, 1};
        tbl[2] = '{3, P_RAND,  -1, 0, -1, 1'b0, 1'b0, 1'b0, 1};
        tbl[3] = '{3, P_KEEP,   1, 5, -1, 1'b0, 1'b0, 1'b0, 1};
        tbl[4] = '{0, P_ONES,  -1, 0, -1, 1'b0, 1'b0, 1'b0, 1};
        tbl[5] = '{5, P_RAND,  -1, 0,  3, 1'b0, 1'b0, 1'b0, 1};
        tbl[6] = '{4, P_RAND,  -1, 0, -1, 1'b1, 1'b1, 1'b1, TMO};
        tbl[7] = '{2, P_ONES,  -1, 0, -1, 1'b0, 1'b1, 1'b0, 1};
        tbl[8] = '{8, P_RAND,   0, 2, -1, 1'b0, 1'b0, 1'b0, 1};

        repeat (3) @(negedge clk);
        chk("reset ctl", RW'({busy, err, op_ready, arr_en, arr_done, res_valid, res_idx}), '0);
        chk("reset skew", RW'({arr_act, arr_wgt}), '0);
        chk("reset row", res_row, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after release", RW'({busy, op_ready, arr_en}), '0);

        // Abandon a tile mid-feed with an asynchronous reset.
        start = 1'b1;
        k_len = 8'd8;
        @(negedge clk);
        start    = 1'b0;
        op_valid = 1'b1;
        op_act   = {N{16'h0101}};
        op_wgt   = {N{16'h0202}};
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("feed reached", RW'({busy, op_ready, arr_en}), RW'(3'b111));
        rst_n = 1'b0;
        #1;
        chk("async reset ctl", RW'({busy, op_ready, arr_en, res_valid, arr_done}), '0);
        chk("async reset skew", RW'({arr_act, arr_wgt}), '0);
        @(negedge clk);
        rst_n    = 1'b1;
        op_valid = 1'b0;
        seen     = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1'b1;
        end
        chk("no activity after reset", RW'(seen), '0);

        for (int i = 0; i < 9; i++) run_tile(i, tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
